time_of_day_clock: RTL
======================

Name: time_of_day_clock

Overview:
- Real-time time-of-day source that drives the hours bus consumed by the traffic controller's day/night converter.
- Counts seconds, minutes and hours from the system clock (1 Hz in the deployed build), with a prescaler for faster bench clocks.
- Exposes a valid/ready set interface so an operator console or test bench can load the time.
- Emits hour and day rollover strobes for logging and mode-scheduling logic.

Parameters:
- TICKS_PER_SEC, 1, clk cycles per counted second (must be ≥1).
- START_HOUR, 6, hour value loaded on reset (0..23).

Ports:
- clk  input  1  system clock (1 Hz when TICKS_PER_SEC=1).
- rst  input  1  reset; asynchronous, active-high.
- run  input  1  1 = time advances; 0 = prescaler and counters frozen.
- setValid  input  1  set request valid.
- setReady  output  1  block can accept a set request.
- setHours  input  5  requested hours, 0..23.
- setMinutes  input  6  requested minutes, 0..59.
- setSeconds  input  6  requested seconds, 0..59.
- setError  output  1  one-cycle pulse: set request rejected (field out of range).
- hoursOut  output  5  current hour, 0..23 (feeds the controller's hours input).
- minutesOut  output  6  current minute, 0..59.
- secondsOut  output  6  current second, 0..59.
- hourTick  output  1  one-cycle pulse on a counted mm:ss 59:59 → 00:00 transition.
- dayRollover  output  1  one-cycle pulse on a counted 23:59:59 → 00:00:00 transition.

Behaviour:
- Reset (async, immediate) sets:
  - hoursOut=START_HOUR, minutesOut=0, secondsOut=0;
  - prescaler=0;
  - FSM=IDLE, setReady=1;
  - setError=0, hourTick=0, dayRollover=0.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 on cycles with run=1 and FSM=IDLE.
  - secStrobe is internal and is true in a cycle where the prescaler equals TICKS_PER_SEC-1 and run=1.
  - The prescaler wraps to 0 on secStrobe.
  - With TICKS_PER_SEC=1, secStrobe fires every cycle with run=1.
- Counting on secStrobe (outputs update on the same clock edge):
  - secondsOut increments; 59 wraps to 0 and carries into minutes.
  - minutesOut 59 wraps to 0 and carries into hours.
  - hoursOut 23 wraps to 0.
  - hourTick=1 in the cycle after a minutes carry into hours.
  - dayRollover=1 in the cycle after an hours wrap, coincident with hourTick.
- FSM has two states, IDLE and APPLY.
  - IDLE: setReady=1. A handshake occurs when setValid=1 and setReady=1 at a clock edge.
  - Valid fields (hours ≤23, minutes ≤59, seconds ≤59):
    - counters load the requested values at that edge;
    - prescaler is cleared to 0;
    - FSM goes to APPLY.
  - Invalid fields:
    - no register change;
    - setError=1 for the following cycle;
    - FSM stays in IDLE.
  - APPLY: lasts exactly 1 cycle.
    - setReady=0, prescaler held at 0, no counting even if run=1.
    - setValid is ignored.
    - Returns to IDLE.
- Simultaneous events:
  - A set handshake and secStrobe in the same cycle: the set wins and that second is dropped.
  - No hourTick or dayRollover is generated by a set, including a set to 00:00:00.
- run=0: counters and prescaler hold, and no strobes are generated. The set interface still works.
- Reset asserted in APPLY or mid-carry returns to reset values. The strobes are forced low immediately.
- setHours, setMinutes and setSeconds are sampled only at the handshake edge.

Test Plan:
- Reset with START_HOUR=6, TICKS_PER_SEC=1, run=1, 10 cycles → time = 06:00:10, setReady=1, no strobes.
- Set 23:59:58 (valid) → setReady=0 for 1 cycle. Over the next 2 cycles the time goes 23:59:58 → 23:59:59 → 00:00:00, with hourTick=1 and dayRollover=1 for exactly one cycle after the wrap.
- Set request with setHours=24, setMinutes=10 → setError pulses 1 cycle, time keeps counting unchanged, setReady stays 1.
- TICKS_PER_SEC=4, run=1 for 12 cycles from reset → secondsOut=3. Toggle run=0 for 5 cycles → no change.
- Set 12:30:00 in the same cycle as a secStrobe → next value 12:30:00 exactly; the first increment occurs TICKS_PER_SEC cycles after APPLY.
- Assert rst during APPLY at 14:59:59 → outputs immediately 06:00:00, setReady=1, hourTick=0.

Source files
------------

// File: rtl/time_of_day_clock.sv
// Time-of-day counter (hh:mm:ss) with a prescaled second strobe, a valid/ready
// time-set port, and hour / day rollover strobes.
module time_of_day_clock #(
  parameter int TICKS_PER_SEC = 1,
  parameter int START_HOUR    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       setValid,
  output logic       setReady,
  input  logic [4:0] setHours,
  input  logic [5:0] setMinutes,
  input  logic [5:0] setSeconds,
  output logic       setError,
  output logic [4:0] hoursOut,
  output logic [5:0] minutesOut,
  output logic [5:0] secondsOut,
  output logic       hourTick,
  output logic       dayRollover
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t           state, stateNext;
  logic [PRE_W-1:0] prescaler;
  logic             handshake, fieldsOk, setAccept, secStrobe, countSec;
  logic             secWrap, minWrap, hourWrap;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    stateNext = state;
    handshake = setValid && (state == IDLE);
    fieldsOk  = (setHours <= 5'd23) && (setMinutes <= 6'd59) && (setSeconds <= 6'd59);
    setAccept = handshake && fieldsOk;
    // The prescaler is parked at 0 in APPLY, so the strobe must also be gated by IDLE.
    secStrobe = run && (state == IDLE) && (prescaler == PRE_LAST);
    countSec  = secStrobe && !setAccept;
    secWrap   = (secondsOut == 6'd59);
    minWrap   = (minutesOut == 6'd59);
    hourWrap  = (hoursOut == 5'd23);
    case (state)
      IDLE:    if (setAccept) stateNext = APPLY;
      APPLY:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      setReady <= 1'b1;
    end else begin
      state    <= stateNext;
      setReady <= (stateNext == IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (setAccept || state == APPLY) begin
      prescaler <= '0;
    end else if (run) begin
      prescaler <= secStrobe ? '0 : prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hoursOut    <= 5'(START_HOUR);
      minutesOut  <= '0;
      secondsOut  <= '0;
      setError    <= 1'b0;
      hourTick    <= 1'b0;
      dayRollover <= 1'b0;
    end else begin
      setError    <= handshake && !fieldsOk;
      hourTick    <= countSec && secWrap && minWrap;
      dayRollover <= countSec && secWrap && minWrap && hourWrap;
      if (setAccept) begin
        hoursOut   <= setHours;
        minutesOut <= setMinutes;
        secondsOut <= setSeconds;
      end else if (countSec) begin
        secondsOut <= secWrap ? 6'd0 : secondsOut + 6'd1;
        if (secWrap) begin
          minutesOut <= minWrap ? 6'd0 : minutesOut + 6'd1;
          if (minWrap) hoursOut <= hourWrap ? 5'd0 : hoursOut + 5'd1;
        end
      end
    end
  end

endmodule
